dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Responder end of the core's load/store data-memory interface: accepts one request at a time from the datapath's memory stage, performs the access against an internal word array, and returns a registered response.
- Supports RV32I access sizes (byte, half, word; signed or unsigned loads) with byte-lane steering, plus a programmable number of wait states.
- Replaces the zero-latency data memory behind the core so that stall handling in the pipeline can be exercised.

Parameters:
- WIDTH, 32, data width in bits; fixed at 32 for RV32I.
- ADDR_W, 10, byte-address width. Array depth is 2**(ADDR_W-2) words.
- WAIT_STATES, 2, extra cycles between accept and response. Legal range is 0..15.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_req  in  1  request valid
- i_we  in  1  1 = store, 0 = load
- i_add  in  ADDR_W  byte address
- i_w_data  in  WIDTH  store data, right-justified
- i_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word)
- i_unsigned  in  1  1 = zero-extend load (LBU/LHU)
- o_ready  out  1  responder can accept; high only in IDLE
- o_stall  out  1  i_req & ~o_ready, combinational; drives the pipeline stall
- o_rvalid  out  1  one-cycle response pulse, issued for loads and stores
- o_r_data  out  WIDTH  load result, valid while o_rvalid
- o_err  out  1  access error, valid while o_rvalid

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low (i_rstn).
- Reset values:
  - state = IDLE, o_ready = 1, o_rvalid = 0, o_r_data = 0, o_err = 0, wait counter = 0.
  - Array contents are not reset.
- FSM has three states: IDLE, WAIT, RESP.
  - IDLE: when i_req & o_ready, latch i_we, i_add, i_w_data, i_size and i_unsigned. Go to WAIT with counter = WAIT_STATES; if WAIT_STATES = 0, go directly to RESP.
  - WAIT: decrement the counter each cycle. When the counter reaches 1, the next edge enters RESP.
  - RESP: o_rvalid = 1 for exactly one cycle, then return to IDLE.
- Latency: accept edge to o_rvalid high is WAIT_STATES+1 cycles. Back-to-back throughput is one request per WAIT_STATES+2 cycles.
- Request inputs are ignored outside IDLE. The initiator holds i_req until it sees o_rvalid.
- The array access happens on the edge that enters RESP. Stores write the array on that edge; loads register o_r_data on that edge.
- Byte lanes are selected by add[1:0]:
  - SB writes i_w_data[7:0] to byte lane add[1:0].
  - SH writes i_w_data[15:0] to the half selected by add[1].
  - SW writes all four lanes.
  - Unselected lanes are unchanged.
- Load extraction:
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - LW returns the full word.
  - o_r_data = 0 in cycles where o_rvalid is low.
- Stores return o_rvalid with o_r_data = 0.
- A load issued after a store to the same address returns the stored value; there is no forwarding hazard, because accesses are serialised.
- Reset asserted mid-transaction aborts it: no write if the RESP-entry edge has not occurred, and no o_rvalid.
- Address bits above ADDR_W are not present; the index wraps naturally modulo the depth.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - A half access with add[0] = 1, or a word access with add[1:0] != 0, completes with normal latency.
  - The response carries o_err = 1, o_r_data = 0, and no array write.
- Undefined:
  - The misaligning low bits are forced to 0: half uses add[0] = 0; word uses add[1:0] = 00.
  - The access proceeds normally; o_err stays 0.

Test Plan:
- WAIT_STATES = 2: SW 0xDEADBEEF to 0x010, then LW from 0x010 -> o_rvalid exactly 3 cycles after each accept, LW returns 0xDEADBEEF, o_stall high during WAIT and RESP.
- Byte lanes: SW 0x00000000 to 0x020, SB 0x80 to 0x023, SH 0xA5A5 to 0x020 -> LW 0x020 returns 0x8000A5A5. LB 0x023 returns 0xFFFFFF80; LBU 0x023 returns 0x00000080.
- Sign extension: SH 0x8001 to 0x042 -> LH 0x042 returns 0xFFFF8001; LHU returns 0x00008001.
- WAIT_STATES = 0: alternating store/load every 2 cycles for 16 transactions -> each o_rvalid 1 cycle after accept, all loads match a scoreboard.
- Reset mid-op: SW 0x12345678 to 0x030, deassert i_rstn during WAIT -> all outputs at reset values; after release, LW 0x030 returns the prior contents.
- Misaligned LW from 0x012:
  - With DMEM_MISALIGN_TRAP_EN: o_err = 1, o_r_data = 0; a misaligned SW leaves memory unchanged.
  - Without it: o_err = 0, and the word at 0x010 is returned.

Source files
------------

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Responder end of the core's load/store data-memory interface. Accepts one
// request at a time, holds it for WAIT_STATES extra cycles, then performs the
// access against an internal word array and returns a one-cycle registered
// response. Byte/half/word accesses with RV32I byte-lane steering and
// signed/unsigned load extension.
//
// Build option:
//   DMEM_MISALIGN_TRAP_EN  defined   -> misaligned half/word accesses complete
//                                       with o_err = 1, o_r_data = 0, no write
//                          undefined -> misaligning low address bits are forced
//                                       to zero and the access proceeds
//
// Parameters:
//   WIDTH        data width (fixed at 32)
//   ADDR_W       byte-address width; array depth is 2**(ADDR_W-2) words
//   WAIT_STATES  extra cycles between accept and response (0..15)
//
// Ports:
//   i_clk        clock
//   i_rstn       asynchronous active-low reset
//   i_req        request valid (held by the initiator until o_rvalid)
//   i_we         1 = store, 0 = load
//   i_add        byte address
//   i_w_data     store data, right-justified
//   i_size       00 byte, 01 half, 10 word, 11 treated as word
//   i_unsigned   1 = zero-extend byte/half loads
//   o_ready      high only while idle
//   o_stall      i_req & ~o_ready (combinational)
//   o_rvalid     one-cycle response pulse for loads and stores
//   o_r_data     load result while o_rvalid, otherwise 0
//   o_err        access error while o_rvalid
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int WIDTH       = 32,
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_add,
    input  logic [WIDTH-1:0]  i_w_data,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    output logic              o_ready,
    output logic              o_stall,
    output logic              o_rvalid,
    output logic [WIDTH-1:0]  o_r_data,
    output logic              o_err
);

    localparam int         DEPTH     = 2 ** (ADDR_W - 2);
    localparam int         LANES     = 4;
    localparam bit         ZERO_WAIT = (WAIT_STATES == 0);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t     state;
    logic [3:0] wait_cnt;

    // Request captured at accept; data-path only, so no reset.
    logic              req_we_p0;
    logic [ADDR_W-1:0] req_add_p0;
    logic [WIDTH-1:0]  req_w_data_p0;
    logic [1:0]        req_size_p0;
    logic              req_unsigned_p0;

    logic [WIDTH-1:0] mem [DEPTH];

    // Byte offset actually used by the access: halves ignore add[0], words
    // ignore add[1:0]. When misalignment traps, the offset is never used.
    function automatic logic [1:0] align_offset(input logic [1:0] size,
                                                input logic [1:0] off);
        case (size)
            2'b00:   return off;
            2'b01:   return {off[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [LANES-1:0] lane_mask(input logic [1:0] size,
                                                   input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the right-justified store data across every lane it may land
    // in; the lane mask then picks the lanes that are written.
    function automatic logic [WIDTH-1:0] store_lanes(input logic [1:0]       size,
                                                     input logic [WIDTH-1:0] data);
        case (size)
            2'b00:   return {4{data[7:0]}};
            2'b01:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] load_extend(input logic [WIDTH-1:0] word,
                                                     input logic [1:0]       size,
                                                     input logic [1:0]       off,
                                                     input logic             uns);
        logic        [WIDTH-1:0] shifted;
        logic signed [7:0]       byte_s;
        logic signed [15:0]      half_s;
        logic signed [WIDTH-1:0] ext;
        shifted = word >> {off, 3'b000};
        byte_s  = shifted[7:0];
        half_s  = shifted[15:0];
        case (size)
            2'b00: begin
                if (uns) ext = {{(WIDTH-8){1'b0}}, shifted[7:0]};
                else     ext = WIDTH'(byte_s);
            end
            2'b01: begin
                if (uns) ext = {{(WIDTH-16){1'b0}}, shifted[15:0]};
                else     ext = WIDTH'(half_s);
            end
            default: ext = word;
        endcase
        return $unsigned(ext);
    endfunction

    // With zero wait states the access happens on the accept edge itself, so
    // while idle the access fields come straight from the request inputs.
    logic              acc_we;
    logic [ADDR_W-1:0] acc_add;
    logic [WIDTH-1:0]  acc_w_data;
    logic [1:0]        acc_size;
    logic              acc_unsigned;

    assign acc_we       = (state == IDLE) ? i_we       : req_we_p0;
    assign acc_add      = (state == IDLE) ? i_add      : req_add_p0;
    assign acc_w_data   = (state == IDLE) ? i_w_data   : req_w_data_p0;
    assign acc_size     = (state == IDLE) ? i_size     : req_size_p0;
    assign acc_unsigned = (state == IDLE) ? i_unsigned : req_unsigned_p0;

    logic [1:0]        acc_off;
    logic [ADDR_W-3:0] acc_idx;
    logic              acc_trap;

    assign acc_off = align_offset(acc_size, acc_add[1:0]);
    assign acc_idx = acc_add[ADDR_W-1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
    logic acc_misaligned;
    assign acc_misaligned = ((acc_size == 2'b01) && acc_add[0]) ||
                            (acc_size[1] && (acc_add[1:0] != 2'b00));
    assign acc_trap = acc_misaligned;
`else
    assign acc_trap = 1'b0;
`endif

    logic             accept;
    logic             enter_resp;
    logic             wr_fire;
    logic [LANES-1:0] wr_mask;
    logic [WIDTH-1:0] wr_lanes;
    logic [WIDTH-1:0] resp_data;

    assign accept     = (state == IDLE) && i_req && o_ready;
    assign enter_resp = (accept && ZERO_WAIT) || ((state == WAIT) && (wait_cnt == 4'd1));
    assign wr_fire    = enter_resp && acc_we && !acc_trap;
    assign wr_mask    = lane_mask(acc_size, acc_off);
    assign wr_lanes   = store_lanes(acc_size, acc_w_data);
    assign resp_data  = (acc_we || acc_trap) ? '0
                                             : load_extend(mem[acc_idx], acc_size, acc_off, acc_unsigned);

    assign o_stall = i_req && !o_ready;

    // Stage p0: request capture and array write on the RESP-entry edge.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            req_we_p0       <= i_we;
            req_add_p0      <= i_add;
            req_w_data_p0   <= i_w_data;
            req_size_p0     <= i_size;
            req_unsigned_p0 <= i_unsigned;
        end
        if (wr_fire) begin
            for (int l = 0; l < LANES; l++) begin
                if (wr_mask[l]) mem[acc_idx][l*8 +: 8] <= wr_lanes[l*8 +: 8];
            end
        end
    end

    // Control FSM with registered handshake/response outputs. Reset drops
    // any transaction in flight; because the write is tied to RESP entry, an
    // aborted store never reaches the array.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            o_ready  <= 1'b1;
            o_rvalid <= 1'b0;
            o_r_data <= '0;
            o_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        o_ready <= 1'b0;
                        if (ZERO_WAIT) begin
                            state    <= RESP;
                            o_rvalid <= 1'b1;
                            o_r_data <= resp_data;
                            o_err    <= acc_trap;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd1) begin
                        state    <= RESP;
                        wait_cnt <= 4'd0;
                        o_rvalid <= 1'b1;
                        o_r_data <= resp_data;
                        o_err    <= acc_trap;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    o_ready  <= 1'b1;
                    o_rvalid <= 1'b0;
                    o_r_data <= '0;
                    o_err    <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= 4'd0;
                    o_ready  <= 1'b1;
                    o_rvalid <= 1'b0;
                    o_r_data <= '0;
                    o_err    <= 1'b0;
                end
            endcase
        end
    end

endmodule
